// File: rtl/mem_block_responder.sv
// mem_block_responder: block memory endpoint answering each request after a fixed latency.
// Define MEM_BLOCK_RESPONDER_STALL_EN for LFSR-driven pseudo-random backpressure on mem_ready_o.
module mem_block_responder #(
   parameter int AddressWidth           = 32,
   parameter int BlockIdxBits           = 4,
   parameter int OutstandingReqIdxWidth = 3,
   parameter int WarpWidth              = 4,
   parameter int NumBlocksIdxBits       = 8,
   parameter int Latency                = 2,
   localparam int BlockWidth     = 2 ** BlockIdxBits,
   localparam int ThreadIdxWidth = (WarpWidth > 1) ? $clog2(WarpWidth) : 1,
   localparam int BlockAddrWidth = AddressWidth - BlockIdxBits,
   localparam int ReqIdWidth     = OutstandingReqIdxWidth + ThreadIdxWidth
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   output logic                      mem_ready_o,
   input  logic                      mem_req_valid_i,
   input  logic [ReqIdWidth-1:0]     mem_req_id_i,
   input  logic [BlockAddrWidth-1:0] mem_req_addr_i,
   input  logic [BlockWidth-1:0]     mem_req_we_mask_i,
   input  logic [8*BlockWidth-1:0]   mem_req_wdata_i,
   output logic                      mem_rsp_valid_o,
   output logic [ReqIdWidth-1:0]     mem_rsp_id_o,
   output logic [8*BlockWidth-1:0]   mem_rsp_data_o
);
   localparam int NumBlocks = 2 ** NumBlocksIdxBits;

   logic [8*BlockWidth-1:0]   mem_q [NumBlocks];
   logic [NumBlocksIdxBits-1:0] idx;
   logic                      accept;
   logic                      wr;
   logic [8*BlockWidth-1:0]   rd;
   logic [8*BlockWidth-1:0]   blk;
   logic                      vld_d;
   logic [ReqIdWidth-1:0]     id_d;
   logic [8*BlockWidth-1:0]   dat_d;
   logic [Latency-1:0]        vld_q;
   logic [ReqIdWidth-1:0]     id_q [Latency];
   logic [8*BlockWidth-1:0]   dat_q [Latency];
   logic                      unused_addr_hi;

`ifdef MEM_BLOCK_RESPONDER_STALL_EN
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign mem_ready_o = !rst_i && (lfsr_q[1:0] != 2'b00);

   always_ff @(posedge clk_i) begin
      lfsr_q <= rst_i ? 16'hACE1 : lfsr_d;
   end
`else
   assign mem_ready_o = !rst_i;
`endif

   // Upper block-address bits alias onto the same memory row.
   assign idx            = mem_req_addr_i[NumBlocksIdxBits-1:0];
   assign unused_addr_hi = ^mem_req_addr_i[BlockAddrWidth-1:NumBlocksIdxBits];
   assign accept         = mem_req_valid_i && mem_ready_o;
   assign wr             = accept && (|mem_req_we_mask_i);
   assign rd             = mem_q[idx];

   always_comb begin
      blk = '0;
      for (int b = 0; b < BlockWidth; b++)
         blk[8*b +: 8] = mem_req_we_mask_i[b] ? mem_req_wdata_i[8*b +: 8] : rd[8*b +: 8];
   end

   // Idle stages carry zeros so the response bus is clean whenever valid is low.
   assign vld_d = accept;
   assign id_d  = accept ? mem_req_id_i : '0;
   assign dat_d = accept ? blk : '0;

   always_ff @(posedge clk_i) begin
      if (wr)
         mem_q[idx] <= blk;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q <= '0;
         for (int i = 0; i < Latency; i++) begin
            id_q[i]  <= '0;
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= vld_d;
         id_q[0]  <= id_d;
         dat_q[0] <= dat_d;
         for (int i = 1; i < Latency; i++) begin
            vld_q[i] <= vld_q[i-1];
            id_q[i]  <= id_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign mem_rsp_valid_o = vld_q[Latency-1];
   assign mem_rsp_id_o    = id_q[Latency-1];
   assign mem_rsp_data_o  = dat_q[Latency-1];

   if (Latency < 1 || Latency > 8) begin : g_bad_latency
      $error("mem_block_responder: Latency must be within 1..8");
   end

   a_req_known: assert property (@(posedge clk_i) disable iff (rst_i)
      mem_req_valid_i |-> !$isunknown({mem_req_id_i, mem_req_addr_i, mem_req_we_mask_i, mem_req_wdata_i}));
endmodule

// File: tb/tb_mem_block_responder.sv
// tb_mem_block_responder: directed vector table plus random traffic, checked by a latency-tagged scoreboard.
module tb_mem_block_responder;
   localparam int L  = 2;
   localparam int AW = 28;
   localparam int IW = 5;

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   mask;
      logic [127:0]  wdata;
      logic [IW-1:0] id;
      logic [127:0]  exp;
   } vec_t;

   typedef struct {
      logic [IW-1:0] id;
      logic [127:0]  data;
      int            due;
   } sb_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_ready_o;
   logic          mem_req_valid;
   logic [IW-1:0] mem_req_id;
   logic [AW-1:0] mem_req_addr;
   logic [15:0]   mem_req_we_mask;
   logic [127:0]  mem_req_wdata;
   logic          mem_rsp_valid;
   logic [IW-1:0] mem_rsp_id;
   logic [127:0]  mem_rsp_data;

   logic [127:0]  model [256];
   logic [15:0]   lfsr_m;
   logic          exp_rdy;
   logic          use_tbl;
   logic [127:0]  tbl_exp;
   sb_t           sb [$];
   vec_t          tbl [7];
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;

   mem_block_responder dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .mem_ready_o       (mem_ready_o),
      .mem_req_valid_i   (mem_req_valid),
      .mem_req_id_i      (mem_req_id),
      .mem_req_addr_i    (mem_req_addr),
      .mem_req_we_mask_i (mem_req_we_mask),
      .mem_req_wdata_i   (mem_req_wdata),
      .mem_rsp_valid_o   (mem_rsp_valid),
      .mem_rsp_id_o      (mem_rsp_id),
      .mem_rsp_data_o    (mem_rsp_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      lfsr_m <= rst ? 16'hACE1 : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};

`ifdef MEM_BLOCK_RESPONDER_STALL_EN
   assign exp_rdy = !rst && (lfsr_m[1:0] != 2'b00);
`else
   assign exp_rdy = !rst;
`endif

   function automatic void chk(string n, logic [127:0] a, logic [127:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", n, a, e, cyc);
      end
   endfunction

   // Acceptance side: model the memory and push the expected response with its due edge.
   always @(posedge clk) begin
      if (rst) begin
         sb.delete();
      end else if (mem_req_valid && exp_rdy) begin
         logic [127:0] m;
         logic [7:0]   ix;
         ix = mem_req_addr[7:0];
         m  = model[ix];
         for (int b = 0; b < 16; b++)
            if (mem_req_we_mask[b]) m[8*b +: 8] = mem_req_wdata[8*b +: 8];
         model[ix] = m;
         sb.push_back('{id: mem_req_id, data: use_tbl ? tbl_exp : m, due: cyc + L});
      end
   end

   // Response side: at each negedge, cyc is the index of the edge that will sample the outputs.
   always @(negedge clk) begin
      if (cyc > 0) begin
         logic exp_now;
         while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
         exp_now = (sb.size() > 0) && (sb[0].due == cyc);
         chk("ready", mem_ready_o, exp_rdy);
         chk("rsp_valid", mem_rsp_valid, exp_now);
         if (mem_rsp_valid && exp_now) begin
            sb_t e;
            e = sb.pop_front();
            chk("rsp_id", mem_rsp_id, e.id);
            chk("rsp_data", mem_rsp_data, e.data);
         end else if (!mem_rsp_valid) begin
            chk("idle_id", mem_rsp_id, 0);
            chk("idle_data", mem_rsp_data, 0);
         end
      end
   end

   task automatic send(input logic [AW-1:0] a, input logic [15:0] m, input logic [127:0] d, input logic [IW-1:0] id);
      logic ok;
      mem_req_valid   = 1'b1;
      mem_req_addr    = a;
      mem_req_we_mask = m;
      mem_req_wdata   = d;
      mem_req_id      = id;
      for (int n = 0; n < 64; n++) begin
         ok = exp_rdy;
         @(posedge clk);
         #1;
         if (ok) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: request id %0d not accepted within 64 cycles", id);
   endtask

   task automatic idle(input int n);
      mem_req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      mem_req_valid   = 1'b0;
      mem_req_id      = '0;
      mem_req_addr    = '0;
      mem_req_we_mask = '0;
      mem_req_wdata   = '0;
      use_tbl         = 1'b0;
      tbl_exp         = '0;
      tbl[0] = '{28'h0000010, 16'hFFFF, 128'h0f0e0d0c0b0a09080706050403020100, 5'd5, 128'h0f0e0d0c0b0a09080706050403020100};
      tbl[1] = '{28'h0000010, 16'h0000, 128'h0, 5'd6, 128'h0f0e0d0c0b0a09080706050403020100};
      tbl[2] = '{28'h0000010, 16'h0003, 128'hffffffffffffffffffffffffffffbbaa, 5'd1, 128'h0f0e0d0c0b0a0908070605040302bbaa};
      tbl[3] = '{28'h0000010, 16'h0000, 128'h0, 5'd2, 128'h0f0e0d0c0b0a0908070605040302bbaa};
      tbl[4] = '{28'h0000110, 16'hFFFF, 128'hdeadbeef0123456789abcdefcafef00d, 5'd3, 128'hdeadbeef0123456789abcdefcafef00d};
      tbl[5] = '{28'h0000010, 16'h0000, 128'h0, 5'd4, 128'hdeadbeef0123456789abcdefcafef00d};
      tbl[6] = '{28'h5a00110, 16'h0000, 128'h0, 5'd31, 128'hdeadbeef0123456789abcdefcafef00d};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", mem_ready_o, 0);
      chk("reset_valid", mem_rsp_valid, 0);
      chk("reset_id", mem_rsp_id, 0);
      chk("reset_data", mem_rsp_data, 0);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", mem_ready_o, 1);

      for (int a = 0; a < 256; a++)
         send(AW'(a), 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, IW'($urandom));

      use_tbl = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tbl_exp = tbl[i].exp;
         send(tbl[i].addr, tbl[i].mask, tbl[i].wdata, tbl[i].id);
      end
      use_tbl = 1'b0;

      for (int i = 0; i < 8; i++)
         send(AW'(i), 16'h0000, 128'h0, IW'(i));
      idle(L + 2);

      send(28'h20, 16'h0000, 128'h0, 5'd10);
      send(28'h21, 16'h0000, 128'h0, 5'd11);
      mem_req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("ready_after_midflight_reset", mem_ready_o, 1);
      idle(L + 4);

      for (int i = 0; i < 100; i++)
         send(AW'({$urandom, $urandom}), ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, IW'($urandom));
      idle(L + 4);
      chk("scoreboard_drained", 128'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
